mem_load_wb: RTL and testbench
==============================

# mem_load_wb

Memory-stage pipeline register and load-result formatter for the SRAM-interface CPU. It captures the dcache-stage result and sign/zero-aligns load data returned by the data SRAM. It holds that data safely across stalls, and drives the mem-stage write port (`mem_we`/`mem_waddr`/`mem_wdata`) consumed by the forwarding unit and the register-file write port. It is the producer for the mem-stage forwarding inputs; load data it emits is final, so the forwarding unit never stalls on mem.

## Interface
- No parameters; widths come from `defines.vh` (`RegBus`=32, `RegAddrBus`=5, `StallBus`=6).
- `clk` in 1 — single clock, rising edge.
- `resetn` in 1 — asynchronous, active-low reset.
- `flush` in 1 — exception flush; squashes the mem stage.
- `stall` in `StallBus` — pipeline stall vector; bit 4 = dcache stage, bit 5 = mem stage.
- `dc_we` in 1 — dcache-stage register write enable.
- `dc_waddr` in 5 — destination register.
- `dc_wdata` in 32 — ALU/non-load result.
- `dc_ram_ctrl` in 5 — [4] data-RAM enable, [3:0] byte write strobes; load = `[4] & ~|[3:0]`.
- `dc_load_op` in 3 — load type (encoding in Structure).
- `dc_addr_lo` in 2 — low two bits of the load address.
- `data_sram_rdata` in 32 — SRAM read data; valid only in the first cycle the load occupies mem.
- `mem_we` out 1 — mem-stage write enable.
- `mem_waddr` out 5 — destination register.
- `mem_wdata` out 32 — final write data (aligned load data or `dc_wdata`).

## Operation
- Stage register (`we`, `waddr`, `wdata`, `is_load`, `load_op`, `addr_lo`). Priority per edge:
  - `flush` → clear to zero.
  - Else if `stall[4]`=Stop and `stall[5]`=NoStop → bubble (clear).
  - Else if `stall[4]`=NoStop → capture `dc_*`.
  - Else hold.
- Read-data FSM, states IDLE / FRESH / HELD:
  - IDLE → FRESH on capture of a load.
  - FRESH: data source is live `data_sram_rdata`. On every edge in FRESH, copy `data_sram_rdata` into `rdata_hold`.
  - FRESH → HELD if the register holds (stall).
  - FRESH → FRESH on capture of a new load; → IDLE on capture of a non-load or a bubble.
  - HELD: data source is `rdata_hold`; it stays HELD while held, and leaves by the same rules as FRESH.
  - `flush` → IDLE from any state.
- Alignment (combinational, source word `w`, byte `b = w[8*addr_lo +: 8]`, half `h = w[16*addr_lo[1] +: 16]`):
  - LB: sign-extend `b`. LBU: zero-extend `b`.
  - LH: sign-extend `h`. LHU: zero-extend `h`.
  - LW and reserved codes 6/7: `w`.
- `mem_wdata` = aligned data if `is_load`, else the registered `wdata`.
- `mem_we` = registered `we`. A store (`dc_ram_ctrl[3:0]`≠0) is never a load; it passes `wdata` through.
- Misaligned LH/LW addresses are not checked here; the exception unit flushes them.

## Timing
- Reset (`resetn` low, asynchronous): all stage registers, `rdata_hold` and outputs are 0; FSM is IDLE. Outputs are 0 immediately, without waiting for a clock.
- Latency: `dc_*` is visible on `mem_*` one cycle after capture.
- For loads, `mem_wdata` is combinational from `data_sram_rdata` in the FRESH cycle (critical path: SRAM → align → forward mux). It is registered from `rdata_hold` in HELD.
- Simultaneous flush and capture: flush wins.
- Back-to-back loads with no stall: FSM stays FRESH; each uses live rdata in its own cycle.
- A stall arriving in the FRESH cycle never loses data; `mem_wdata` is constant for the whole stall.
- Bubble insertion leaves `mem_we`=0 the next cycle.

## Structure
- `defines.vh` additions: `LoadNone`=3'd0, `LoadB`=1, `LoadBU`=2, `LoadH`=3, `LoadHU`=4, `LoadW`=5; FSM state codes `MemIdle`/`MemFresh`/`MemHeld`. Reuse the existing `Stop`/`NoStop` and `StallBus`.
- One combinational sub-module, `load_align` (inputs: `w`, `load_op`, `addr_lo`; output: 32-bit data), shared with any future uncached-load path.

## Test plan
- **Reset:** assert `resetn`=0 mid-load with `mem_we`=1 → all outputs 0 asynchronously; FSM is IDLE after release.
- **Byte alignment:** LB, `addr_lo`=3, `data_sram_rdata`=0x80FF_1234 → `mem_wdata`=0xFFFF_FF80. LBU, same inputs → 0x0000_0080.
- **Halfword alignment:** LH, `addr_lo`=2, rdata=0x8001_7FFF → 0xFFFF_8001. LHU, `addr_lo`=0 → 0x0000_7FFF.
- **Stall hold:** LW captured with rdata=0xDEAD_BEEF, then `stall[5]`=Stop for 3 cycles while rdata changes to 0x0 → `mem_wdata`=0xDEAD_BEEF throughout; FSM goes FRESH→HELD.
- **Bubble and flush:** `stall[4]`=Stop, `stall[5]`=NoStop → next cycle `mem_we`=0. `flush` together with a valid capture → `mem_we`=0, FSM IDLE.
- **Non-load pass-through:** store (`ram_ctrl`=5'b1_1111), `dc_we`=0 → `mem_we`=0. ALU op with `dc_wdata`=0x1234_5678, `waddr`=9 → `mem_wdata`=0x1234_5678, `mem_waddr`=9 one cycle later.

Source files
------------

// File: rtl/mem_load_wb_pkg.sv
// Shared widths, stall polarity, load-type codes and mem-stage FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_load_wb_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int StallBus   = 6;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [2:0] LoadNone = 3'd0;
  localparam logic [2:0] LoadB    = 3'd1;
  localparam logic [2:0] LoadBU   = 3'd2;
  localparam logic [2:0] LoadH    = 3'd3;
  localparam logic [2:0] LoadHU   = 3'd4;
  localparam logic [2:0] LoadW    = 3'd5;

  typedef enum logic [1:0] {
    MemIdle  = 2'd0,
    MemFresh = 2'd1,
    MemHeld  = 2'd2
  } mem_state_e;

  // A data-RAM access with no write strobes is a load; any strobe makes it a store.
  function automatic logic is_load_ctrl(input logic [4:0] ram_ctrl);
    return ram_ctrl[4] & ~(|ram_ctrl[3:0]);
  endfunction

endpackage

// File: rtl/mem_load_wb_load_align.sv
// Extracts and sign/zero-extends the addressed byte/halfword of a load word.
// Latency: purely combinational.
// Backpressure: none; no state.
module load_align
  import mem_load_wb_pkg::*;
(
  input  logic [31:0] w,
  input  logic [2:0]  load_op,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  // Select byte/half lanes by address, then extend according to the load type.
  always_comb begin
    b    = w[{addr_lo, 3'b000} +: 8];
    h    = w[{addr_lo[1], 4'b0000} +: 16];
    data = w;
    case (load_op)
      LoadB:   data = {{24{b[7]}}, b};
      LoadBU:  data = {24'd0, b};
      LoadH:   data = {{16{h[15]}}, h};
      LoadHU:  data = {16'd0, h};
      default: data = w;
    endcase
  end

endmodule

// File: rtl/mem_load_wb.sv
// Mem-stage pipeline register; formats load data from the data SRAM and drives the mem write port.
// Latency: dc_* appears on mem_* one cycle after capture; load data is live from SRAM in its first cycle.
// Backpressure: stall[4]/stall[5] hold or bubble the stage; SRAM data is latched so a stall never loses it.
module mem_load_wb
  import mem_load_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic [StallBus-1:0]   stall,
  input  logic                  dc_we,
  input  logic [RegAddrBus-1:0] dc_waddr,
  input  logic [RegBus-1:0]     dc_wdata,
  input  logic [4:0]            dc_ram_ctrl,
  input  logic [2:0]            dc_load_op,
  input  logic [1:0]            dc_addr_lo,
  input  logic [RegBus-1:0]     data_sram_rdata,
  output logic                  mem_we,
  output logic [RegAddrBus-1:0] mem_waddr,
  output logic [RegBus-1:0]     mem_wdata
);

  logic                  we_q;
  logic [RegAddrBus-1:0] waddr_q;
  logic [RegBus-1:0]     wdata_q;
  logic                  is_load_q;
  logic [2:0]            load_op_q;
  logic [1:0]            addr_lo_q;
  logic [RegBus-1:0]     rdata_hold;
  mem_state_e            state_q, state_d;

  logic              capture, bubble, dc_is_load;
  logic [RegBus-1:0] align_src, aligned;
  logic              stall_unused;

  // Upstream stopped while mem moves on: insert a bubble. Upstream moving: take new work.
  assign bubble       = (stall[4] == Stop) && (stall[5] == NoStop);
  assign capture      = (stall[4] == NoStop);
  assign dc_is_load   = is_load_ctrl(dc_ram_ctrl);
  assign stall_unused = ^stall[3:0];

  // Stage register: flush beats bubble beats capture; otherwise hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_q <= 1'b0; waddr_q <= '0; wdata_q <= '0;
      is_load_q <= 1'b0; load_op_q <= '0; addr_lo_q <= '0;
    end else if (flush || bubble) begin
      we_q <= 1'b0; waddr_q <= '0; wdata_q <= '0;
      is_load_q <= 1'b0; load_op_q <= '0; addr_lo_q <= '0;
    end else if (capture) begin
      we_q      <= dc_we;
      waddr_q   <= dc_waddr;
      wdata_q   <= dc_wdata;
      is_load_q <= dc_is_load;
      load_op_q <= dc_load_op;
      addr_lo_q <= dc_addr_lo;
    end
  end

  // Read-data FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= MemIdle;
    else         state_q <= state_d;
  end

  // Next state: a load's first cycle is FRESH; if it is held past that, it switches to the latched copy.
  always_comb begin
    state_d = state_q;
    if (flush || bubble)      state_d = MemIdle;
    else if (capture)         state_d = dc_is_load ? MemFresh : MemIdle;
    else if (state_q == MemFresh) state_d = MemHeld;
  end

  // SRAM data is only valid in the FRESH cycle, so snapshot it on every edge spent there.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                  rdata_hold <= '0;
    else if (state_q == MemFresh) rdata_hold <= data_sram_rdata;
  end

  assign align_src = (state_q == MemHeld) ? rdata_hold : data_sram_rdata;

  load_align u_load_align (
    .w       (align_src),
    .load_op (load_op_q),
    .addr_lo (addr_lo_q),
    .data    (aligned)
  );

  assign mem_we    = we_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = is_load_q ? aligned : wdata_q;

endmodule

// File: tb/tb_mem_load_wb.sv
module tb_mem_load_wb;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic [5:0]  stall;
  logic        dc_we;
  logic [4:0]  dc_waddr;
  logic [31:0] dc_wdata;
  logic [4:0]  dc_ram_ctrl;
  logic [2:0]  dc_load_op;
  logic [1:0]  dc_addr_lo;
  logic [31:0] data_sram_rdata;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: contents of the mem stage and the word a load saw in its first cycle.
  logic        m_we, m_load, m_first;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata, m_saved;
  int          m_op, m_lo;

  mem_load_wb dut (
    .clk(clk), .resetn(resetn), .flush(flush), .stall(stall),
    .dc_we(dc_we), .dc_waddr(dc_waddr), .dc_wdata(dc_wdata),
    .dc_ram_ctrl(dc_ram_ctrl), .dc_load_op(dc_load_op), .dc_addr_lo(dc_addr_lo),
    .data_sram_rdata(data_sram_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  lo;
    logic [4:0]  ctrl;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_align(input logic [31:0] w, input int op, input int lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * lo));
    h = 16'(w >> (16 * (lo / 2)));
    case (op)
      1: return 32'($signed(b));
      2: return 32'(b);
      3: return 32'($signed(h));
      4: return 32'(h);
      default: return w;
    endcase
  endfunction

  task automatic model_clear();
    m_we = 0; m_load = 0; m_first = 0; m_waddr = 0; m_wdata = 0; m_op = 0; m_lo = 0;
  endtask

  // Apply the stage rules for one rising edge, using the inputs the bench is driving.
  task automatic model_edge();
    if (flush || (stall[4] && !stall[5])) model_clear();
    else if (!stall[4]) begin
      m_we = dc_we; m_waddr = dc_waddr; m_wdata = dc_wdata;
      m_load = dc_ram_ctrl[4] && (dc_ram_ctrl[3:0] == 4'd0);
      m_op = int'(dc_load_op); m_lo = int'(dc_addr_lo);
      m_first = m_load;
    end else m_first = 0;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] exp_d;
    if (m_load) begin
      if (m_first) m_saved = data_sram_rdata;
      exp_d = ref_align(m_saved, m_op, m_lo);
    end else exp_d = m_wdata;
    chk({tag, ".we"}, 32'(mem_we), 32'(m_we));
    chk({tag, ".waddr"}, 32'(mem_waddr), 32'(m_waddr));
    chk({tag, ".wdata"}, mem_wdata, exp_d);
  endtask

  // One clock: edge, model update, present this cycle's SRAM data, then compare.
  task automatic tick(input string tag, input logic [31:0] rd);
    @(posedge clk);
    model_edge();
    #1 data_sram_rdata = rd;
    #1 check_model(tag);
  endtask

  task automatic drive(input logic [4:0] ctrl, input logic [2:0] op, input logic [1:0] lo,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    dc_ram_ctrl = ctrl; dc_load_op = op; dc_addr_lo = lo;
    dc_we = we; dc_waddr = wa; dc_wdata = wd;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{3'd1, 2'd3, 5'b10000, 1'b1, 5'd3, 32'h0, 32'h80FF_1234, 1'b1, 5'd3, 32'hFFFF_FF80};
    vecs[1] = '{3'd2, 2'd3, 5'b10000, 1'b1, 5'd3, 32'h0, 32'h80FF_1234, 1'b1, 5'd3, 32'h0000_0080};
    vecs[2] = '{3'd3, 2'd2, 5'b10000, 1'b1, 5'd4, 32'h0, 32'h8001_7FFF, 1'b1, 5'd4, 32'hFFFF_8001};
    vecs[3] = '{3'd4, 2'd0, 5'b10000, 1'b1, 5'd4, 32'h0, 32'h8001_7FFF, 1'b1, 5'd4, 32'h0000_7FFF};
    vecs[4] = '{3'd5, 2'd0, 5'b10000, 1'b1, 5'd5, 32'h0, 32'hDEAD_BEEF, 1'b1, 5'd5, 32'hDEAD_BEEF};
    vecs[5] = '{3'd0, 2'd0, 5'b11111, 1'b0, 5'd6, 32'hAAAA_5555, 32'h1111_2222, 1'b0, 5'd6, 32'hAAAA_5555};
    vecs[6] = '{3'd0, 2'd0, 5'b00000, 1'b1, 5'd9, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 5'd9, 32'h1234_5678};
    vecs[7] = '{3'd1, 2'd1, 5'b10000, 1'b1, 5'd7, 32'h0, 32'h0000_7F00, 1'b1, 5'd7, 32'h0000_007F};
    vecs[8] = '{3'd6, 2'd1, 5'b10000, 1'b1, 5'd8, 32'h0, 32'hCAFE_F00D, 1'b1, 5'd8, 32'hCAFE_F00D};

    resetn = 0; flush = 0; stall = 0; data_sram_rdata = 0;
    drive(5'd0, 3'd0, 2'd0, 1'b0, 5'd0, 32'd0);
    model_clear(); m_saved = 0;
    #1;
    chk("reset.we", 32'(mem_we), 32'd0);
    chk("reset.wdata", mem_wdata, 32'd0);
    @(negedge clk); resetn = 1;

    // Table of single-transaction formatting cases.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].ctrl, vecs[i].op, vecs[i].lo, vecs[i].we, vecs[i].waddr, vecs[i].wdata);
      tick($sformatf("vec%0d", i), vecs[i].rdata);
      chk($sformatf("vec%0d.tbl_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
      chk($sformatf("vec%0d.tbl_waddr", i), 32'(mem_waddr), 32'(vecs[i].exp_waddr));
      chk($sformatf("vec%0d.tbl_wdata", i), mem_wdata, vecs[i].exp_wdata);
    end

    // Stall hold: LW then mem stalled three cycles while SRAM data goes to zero.
    drive(5'b10000, 3'd5, 2'd0, 1'b1, 5'd10, 32'd0);
    tick("hold0", 32'hDEAD_BEEF);
    stall = 6'b110000;
    drive(5'b00000, 3'd0, 2'd0, 1'b1, 5'd11, 32'h5555_5555);
    for (int i = 0; i < 3; i++) begin
      tick($sformatf("hold%0d", i + 1), 32'h0);
      chk($sformatf("hold%0d.const", i + 1), mem_wdata, 32'hDEAD_BEEF);
    end
    stall = 6'b000000;
    tick("hold_rel", 32'h0);
    chk("hold_rel.alu", mem_wdata, 32'h5555_5555);

    // Back-to-back loads without stall, each using its own live data.
    drive(5'b10000, 3'd1, 2'd0, 1'b1, 5'd12, 32'd0);
    tick("b2b0", 32'h0000_0081);
    chk("b2b0.lb", mem_wdata, 32'hFFFF_FF81);
    drive(5'b10000, 3'd4, 2'd2, 1'b1, 5'd13, 32'd0);
    tick("b2b1", 32'hBEEF_0000);
    chk("b2b1.lhu", mem_wdata, 32'h0000_BEEF);

    // Bubble: upstream stopped, mem free.
    drive(5'b00000, 3'd0, 2'd0, 1'b1, 5'd14, 32'h0000_0042);
    stall = 6'b000000;
    tick("bub0", 32'h0);
    stall = 6'b010000;
    tick("bub1", 32'h0);
    chk("bubble.we", 32'(mem_we), 32'd0);

    // Flush together with a valid capture, then a hold: nothing may reappear.
    stall = 6'b000000; flush = 1;
    drive(5'b10000, 3'd5, 2'd0, 1'b1, 5'd15, 32'd0);
    tick("flush0", 32'h1234_0000);
    chk("flush.we", 32'(mem_we), 32'd0);
    chk("flush.wdata", mem_wdata, 32'd0);
    flush = 0; stall = 6'b110000;
    tick("flush1", 32'h9999_9999);
    chk("flush_hold.wdata", mem_wdata, 32'd0);
    stall = 6'b000000;

    // Asynchronous reset in the middle of a load.
    drive(5'b10000, 3'd5, 2'd0, 1'b1, 5'd16, 32'd0);
    tick("rst0", 32'h7777_7777);
    chk("rst0.we_before", 32'(mem_we), 32'd1);
    #1 resetn = 0;
    #1;
    chk("rst.async_we", 32'(mem_we), 32'd0);
    chk("rst.async_waddr", 32'(mem_waddr), 32'd0);
    chk("rst.async_wdata", mem_wdata, 32'd0);
    model_clear();
    @(negedge clk); resetn = 1; stall = 6'b110000;
    tick("rst_idle", 32'hABCD_EF01);
    stall = 6'b000000;

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      logic [4:0] ctrl;
      case ($urandom_range(2))
        0: ctrl = 5'b10000;
        1: ctrl = {1'b1, 4'($urandom_range(15, 1))};
        default: ctrl = 5'b00000;
      endcase
      drive(ctrl, 3'($urandom_range(7)), 2'($urandom_range(3)), 1'($urandom),
            5'($urandom), $urandom);
      flush = ($urandom_range(15) == 0);
      stall = {1'($urandom), ($urandom_range(2) == 0), 4'($urandom)};
      tick("rnd", $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
